dco_cal_ctrl: RTL

Calibration and lock-supervision controller for the ADPLL's counter-based DCO. After a start request it opens the loop and runs a 5-step successive-approximation (SAR) search on the DCO threshold code so that the DCO rising-edge count per measurement window matches a target. It then closes the loop by releasing the loop-filter gain, and keeps monitoring the edge count to report lock and loss of lock. It sits between the loop filter / configuration registers and the DCO's `kdco`, `thresh_val`, `dco_offset` and `reset` inputs.

---
 rtl/dco_cal_ctrl_if.sv | 28 ++
 rtl/dco_cal_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/dco_cal_ctrl_if.sv
// Control/DCO bundle for dco_cal_ctrl. The slave modport is the controller
// side; the master modport is the host plus the DCO model driving dco_clk.
interface dco_cal_ctrl_if #(parameter int WIN_LOG2 = 6) ();
  logic                start;
  logic [WIN_LOG2-1:0] target_cnt;
  logic [WIN_LOG2-1:0] cfg_tol;
  logic [4:0]          cfg_kdco;
  logic [4:0]          cfg_offset;
  logic                dco_clk;
  logic [4:0]          kdco;
  logic [4:0]          thresh_val;
  logic [4:0]          dco_offset;
  logic                dco_reset;
  logic                busy;
  logic                cal_done;
  logic                locked;
  logic                lost_lock;

  modport slave (
    input  start, target_cnt, cfg_tol, cfg_kdco, cfg_offset, dco_clk,
    output kdco, thresh_val, dco_offset, dco_reset, busy, cal_done, locked, lost_lock
  );

  modport master (
    output start, target_cnt, cfg_tol, cfg_kdco, cfg_offset, dco_clk,
    input  kdco, thresh_val, dco_offset, dco_reset, busy, cal_done, locked, lost_lock
  );
endinterface

// File: rtl/dco_cal_ctrl.sv
// DCO calibration and lock supervisor: 5-step SAR search of the DCO threshold
// code against a per-window edge-count target, then lock monitoring.
// Optional feature macro DCO_CAL_AUTORELOCK_EN: on loss of lock, restart the
// SAR search automatically with the latched configuration.
module dco_cal_ctrl #(
  parameter int WIN_LOG2 = 6,
  parameter int LOSS_CNT = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  dco_cal_ctrl_if.slave  bus
);
  localparam int MW = $clog2(LOSS_CNT + 1);

  typedef enum logic [2:0] {IDLE, TRIAL_RST, MEAS, DECIDE, LOCK} state_t;

  state_t              state, nxt;
  logic [WIN_LOG2-1:0] win_cnt, edge_cnt, cnt_next, tgt_q, tol_q;
  logic [WIN_LOG2:0]   err;
  logic [4:0]          code, code_dec, offset_q;
  logic [2:0]          idx;
  logic [MW-1:0]       miss;
  logic d1, rise, win_last, in_tol, miss_hit, accept;
  logic cal_done_q, dco_reset_q, locked_q, lost_q;

  assign rise     = bus.dco_clk & ~d1;
  assign win_last = &win_cnt;
  // Saturating edge counter; an all-ones count reads as ">= any target".
  assign cnt_next = (&edge_cnt) ? edge_cnt : edge_cnt + WIN_LOG2'(rise);
  assign err      = (cnt_next >= tgt_q) ? ({1'b0, cnt_next} - {1'b0, tgt_q})
                                        : ({1'b0, tgt_q} - {1'b0, cnt_next});
  assign in_tol   = err <= {1'b0, tol_q};
  assign miss_hit = win_last && !in_tol && (int'(miss) + 1 >= LOSS_CNT);
  assign accept   = bus.start && (state == IDLE || state == LOCK);

  assign bus.kdco       = (state == LOCK) ? bus.cfg_kdco : 5'd0;
  assign bus.busy       = (state == TRIAL_RST) || (state == MEAS) || (state == DECIDE);
  assign bus.thresh_val = code;
  assign bus.dco_offset = offset_q;
  assign bus.dco_reset  = dco_reset_q;
  assign bus.cal_done   = cal_done_q;
  assign bus.locked     = locked_q;
  assign bus.lost_lock  = lost_q;

  // SAR step: drop the trial bit if the DCO was too slow, then arm the next bit.
  always_comb begin
    code_dec = code;
    if (edge_cnt < tgt_q) code_dec[idx] = 1'b0;
    if (idx != 3'd0) code_dec[idx - 3'd1] = 1'b1;
  end

  // Next-state logic.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (bus.start) nxt = TRIAL_RST;
      TRIAL_RST: nxt = MEAS;
      MEAS:      if (win_last) nxt = DECIDE;
      DECIDE:    nxt = (idx == 3'd0) ? LOCK : TRIAL_RST;
      LOCK: begin
        if (bus.start) nxt = TRIAL_RST;
`ifdef DCO_CAL_AUTORELOCK_EN
        else if (miss_hit) nxt = TRIAL_RST;
`endif
      end
      default:   nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Counters, SAR code, lock supervision and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1          <= 1'b0;
      win_cnt     <= '0;
      edge_cnt    <= '0;
      tgt_q       <= '0;
      tol_q       <= '0;
      code        <= 5'b10000;
      idx         <= 3'd4;
      miss        <= '0;
      offset_q    <= 5'd0;
      dco_reset_q <= 1'b1;
      cal_done_q  <= 1'b0;
      locked_q    <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      d1          <= (state == TRIAL_RST) ? 1'b0 : bus.dco_clk;
      dco_reset_q <= (nxt == TRIAL_RST);
      cal_done_q  <= (state == DECIDE) && (nxt == LOCK);
      offset_q    <= bus.cfg_offset;

      case (state)
        TRIAL_RST, DECIDE: begin
          win_cnt  <= '0;
          edge_cnt <= '0;
        end
        MEAS: begin
          win_cnt  <= win_cnt + 1'b1;
          edge_cnt <= cnt_next;
        end
        LOCK: begin
          win_cnt  <= win_cnt + 1'b1;
          edge_cnt <= win_last ? '0 : cnt_next;
        end
        default: ;
      endcase

      if (state == DECIDE) begin
        code <= code_dec;
        if (idx != 3'd0) idx <= idx - 3'd1;
      end

      if (state == LOCK && win_last) begin
        if (in_tol) begin
          locked_q <= 1'b1;
          miss     <= '0;
        end else if (miss_hit) begin
          locked_q <= 1'b0;
          lost_q   <= 1'b1;
`ifdef DCO_CAL_AUTORELOCK_EN
          code     <= 5'b10000;
          idx      <= 3'd4;
          miss     <= '0;
`endif
        end else begin
          miss <= miss + 1'b1;
        end
      end

      // Start acceptance wins over any window-end bookkeeping in the same cycle.
      if (accept) begin
        tgt_q    <= bus.target_cnt;
        tol_q    <= bus.cfg_tol;
        code     <= 5'b10000;
        idx      <= 3'd4;
        miss     <= '0;
        locked_q <= 1'b0;
        lost_q   <= 1'b0;
      end
    end
  end
endmodule
